// File: rtl/bus_responder.sv
// bus_responder: memory-mapped target on the processor's ADDR/DOUT/W/DIN port.
// Regions: 0 RAM, 1 LEDR, 3 switches, 4 TX FIFO, 5 free-running timer.
// Reads are side-effect free; DIN is registered (one-cycle read latency).
module bus_responder #(
  parameter int AW = 8,
  parameter int FD = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  output logic [15:0] DIN,
  input  logic [9:0]  SW,
  output logic [9:0]  LEDR,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY
);

  localparam int          PW   = (FD > 1) ? $clog2(FD) : 1;
  localparam logic [4:0]  FD_C = 5'(FD);

  logic [15:0] ram_mem  [2**AW];
  logic [7:0]  fifo_mem [FD];

  logic [15:0] din_q, din_d;
  logic [9:0]  ledr_q, ledr_d;
  logic [15:0] timer_q, timer_d;
  logic [9:0]  sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [4:0]  count_q, count_d;
  logic        ovf_q, ovf_d;

  logic [3:0]  region;
  logic        ram_we, led_we, push, push_ok, fifo_we, ovf_clr, timer_we, pop;
  logic [15:0] status;

  // Address bits above the decoded ranges alias; fold them here so they count as consumed.
  logic unused;
  assign unused = ^{ADDR, DOUT};

  // Decode, read mux and next-state for all registers.
  always_comb begin
    region   = ADDR[15:12];
    ram_we   = W && !Reset && (region == 4'h0);
    led_we   = W && (region == 4'h1);
    push     = W && (region == 4'h4) && !ADDR[0];
    ovf_clr  = W && (region == 4'h4) && ADDR[0] && DOUT[15];
    timer_we = W && (region == 4'h5);
    pop      = (count_q != 5'd0) && TX_READY;
    // A full FIFO still takes a push when a pop frees a slot in the same cycle.
    push_ok  = push && ((count_q < FD_C) || pop);
    fifo_we  = push_ok && !Reset;

    ledr_d    = led_we ? DOUT[9:0] : ledr_q;
    timer_d   = timer_we ? DOUT : timer_q + 16'd1;
    sw_meta_d = SW;
    sw_sync_d = sw_meta_q;

    rd_ptr_d = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (ovf_clr)              ovf_d = 1'b0;
    else if (push && !push_ok) ovf_d = 1'b1;

    status = {ovf_q, (count_q == FD_C), (count_q == 5'd0), 8'b0, count_q};

    din_d = 16'h0000;
    case (region)
      4'h0:    din_d = ram_mem[ADDR[AW-1:0]];
      4'h1:    din_d = {6'b0, ledr_q};
      4'h3:    din_d = {6'b0, sw_sync_q};
      4'h4:    din_d = ADDR[0] ? status : 16'h0000;
      4'h5:    din_d = timer_q;
      default: din_d = 16'h0000;
    endcase
  end

  // Control and data registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      din_q     <= '0;
      ledr_q    <= '0;
      timer_q   <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      din_q     <= din_d;
      ledr_q    <= ledr_d;
      timer_q   <= timer_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage arrays are never reset; writes are blocked while Reset is high.
  always_ff @(posedge Clock) begin
    if (ram_we)  ram_mem[ADDR[AW-1:0]] <= DOUT;
    if (fifo_we) fifo_mem[wr_ptr_q]    <= DOUT[7:0];
  end

  assign DIN      = din_q;
  assign LEDR     = ledr_q;
  assign TX_DATA  = fifo_mem[rd_ptr_q];
  assign TX_VALID = (count_q != 5'd0);

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: directed vector table, then random traffic against a
// behavioural model (array RAM, byte queue FIFO, integer timer).
module tb_bus_responder;
  localparam int FD = 8;

  logic Clock = 0, Reset = 0, W = 0, TX_READY = 0;
  logic [15:0] ADDR = 0, DOUT = 0;
  logic [9:0]  SW = 0;
  logic [15:0] DIN;
  logic [9:0]  LEDR;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;

  bus_responder #(.AW(8), .FD(FD)) dut (
    .Clock(Clock), .Reset(Reset), .ADDR(ADDR), .DOUT(DOUT), .W(W), .DIN(DIN),
    .SW(SW), .LEDR(LEDR), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY));

  always #5 Clock = ~Clock;

  int total = 0, bad = 0;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_ram [256];
  bit          m_ram_ok [256];
  logic [9:0]  m_led = 0, m_s1 = 0, m_s2 = 0;
  logic [15:0] m_timer = 0;
  logic [7:0]  m_q [$];
  bit          m_ovf = 0;
  logic [15:0] m_din;
  bit          m_din_ok;

  task automatic model_step();
    int rg = int'(ADDR[15:12]);
    int sz = m_q.size();
    bit pop;
    m_din_ok = 1;
    m_din = 16'h0;
    if (Reset) begin
      m_led = 0; m_timer = 0; m_s1 = 0; m_s2 = 0; m_q.delete(); m_ovf = 0;
      return;
    end
    case (rg)
      0: begin m_din = m_ram[ADDR[7:0]]; m_din_ok = m_ram_ok[ADDR[7:0]]; end
      1: m_din = {6'b0, m_led};
      3: m_din = {6'b0, m_s2};
      4: if (ADDR[0]) m_din = {m_ovf, sz == FD, sz == 0, 8'b0, 5'(sz)};
      5: m_din = m_timer;
      default: m_din = 0;
    endcase
    pop = (sz > 0) && TX_READY;
    if (pop) void'(m_q.pop_front());
    if (W && rg == 4 && !ADDR[0]) begin
      if (sz < FD || pop) m_q.push_back(DOUT[7:0]);
      else m_ovf = 1;
    end
    if (W && rg == 4 && ADDR[0] && DOUT[15]) m_ovf = 0;
    if (W && rg == 1) m_led = DOUT[9:0];
    if (W && rg == 0) begin m_ram[ADDR[7:0]] = DOUT; m_ram_ok[ADDR[7:0]] = 1; end
    m_timer = (W && rg == 5) ? DOUT : m_timer + 16'd1;
    m_s2 = m_s1;
    m_s1 = SW;
  endtask

  // One clock: update the model from pre-edge inputs, then sample just after the edge.
  task automatic tick();
    model_step();
    @(posedge Clock);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit rst; logic [15:0] addr, dout; bit w, rdy; logic [9:0] sw;
    logic [15:0] edin; logic [9:0] eled; bit evld; logic [7:0] etx;
    logic [3:0] chk;  // 1=DIN 2=LEDR 4=TX_VALID 8=TX_DATA
  } vec_t;
  vec_t tbl [$];

  task automatic add(bit rst, logic [15:0] a, logic [15:0] d, bit w, bit rdy, logic [9:0] sw,
                     logic [15:0] edin, logic [9:0] eled, bit evld, logic [7:0] etx, logic [3:0] c);
    vec_t v;
    v.rst = rst; v.addr = a; v.dout = d; v.w = w; v.rdy = rdy; v.sw = sw;
    v.edin = edin; v.eled = eled; v.evld = evld; v.etx = etx; v.chk = c;
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] heads [7] = '{8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h50};
    // reset with a coincident write, RAM round trip, aliasing, unmapped region
    add(1, 16'h1000, 16'h03FF, 1, 0, 0, 16'h0, 10'h0, 0, 0, 4'h7);
    add(1, 16'h0000, 16'h0, 0, 0, 0, 16'h0, 10'h0, 0, 0, 4'h7);
    add(0, 16'h0012, 16'hBEEF, 1, 0, 0, 16'h0, 10'h0, 0, 0, 4'h6);
    add(0, 16'h0012, 16'h0, 0, 0, 0, 16'hBEEF, 10'h0, 0, 0, 4'h1);
    add(0, 16'h0112, 16'h0, 0, 0, 0, 16'hBEEF, 10'h0, 0, 0, 4'h1);
    add(0, 16'h2000, 16'h0, 0, 0, 0, 16'h0000, 10'h0, 0, 0, 4'h1);
    // LEDs and switches
    add(0, 16'h1000, 16'h03FF, 1, 0, 0, 16'h0000, 10'h3FF, 0, 0, 4'h3);
    add(0, 16'h1000, 16'h0, 0, 0, 0, 16'h03FF, 10'h3FF, 0, 0, 4'h3);
    add(0, 16'h3000, 16'h0, 0, 0, 10'h155, 16'h0000, 10'h3FF, 0, 0, 4'h1);
    add(0, 16'h3000, 16'h0, 0, 0, 10'h155, 16'h0000, 10'h3FF, 0, 0, 4'h0);
    add(0, 16'h3000, 16'h0, 0, 0, 10'h155, 16'h0155, 10'h3FF, 0, 0, 4'h1);
    // FIFO fill, overflow, clear
    for (int i = 0; i < 8; i++)
      add(0, 16'h4000, 16'h0041 + 16'(i), 1, 0, 10'h155, 16'h0, 10'h3FF, 1, 8'h41, 4'hD);
    add(0, 16'h4001, 16'h0, 0, 0, 10'h155, 16'h4008, 10'h3FF, 1, 8'h41, 4'hD);
    add(0, 16'h4000, 16'h0049, 1, 0, 10'h155, 16'h0000, 10'h3FF, 1, 8'h41, 4'hD);
    add(0, 16'h4001, 16'h0, 0, 0, 10'h155, 16'hC008, 10'h3FF, 1, 8'h41, 4'hD);
    add(0, 16'h4001, 16'h8000, 1, 0, 10'h155, 16'hC008, 10'h3FF, 1, 8'h41, 4'hD);
    add(0, 16'h4001, 16'h0, 0, 0, 10'h155, 16'h4008, 10'h3FF, 1, 8'h41, 4'hD);
    // push and pop together while full, then drain
    add(0, 16'h4000, 16'h0050, 1, 1, 10'h155, 16'h0000, 10'h3FF, 1, 8'h42, 4'hD);
    add(0, 16'h4001, 16'h0, 0, 0, 10'h155, 16'h4008, 10'h3FF, 1, 8'h42, 4'hD);
    for (int k = 0; k < 8; k++)
      add(0, 16'h4001, 16'h0, 0, 1, 10'h155, 16'h0, 10'h3FF, k < 7, (k < 7) ? heads[k] : 8'h0,
          (k < 7) ? 4'hC : 4'h4);
    add(0, 16'h4001, 16'h0, 0, 0, 10'h155, 16'h2000, 10'h3FF, 0, 0, 4'h5);
    // timer wrap
    add(0, 16'h5000, 16'hFFFE, 1, 0, 10'h155, 16'h0, 10'h3FF, 0, 0, 4'h0);
    add(0, 16'h5000, 16'h0, 0, 0, 10'h155, 16'hFFFE, 10'h3FF, 0, 0, 4'h1);
    add(0, 16'h5000, 16'h0, 0, 0, 10'h155, 16'hFFFF, 10'h3FF, 0, 0, 4'h1);
    add(0, 16'h5000, 16'h0, 0, 0, 10'h155, 16'h0000, 10'h3FF, 0, 0, 4'h1);
    add(0, 16'h5000, 16'h0, 0, 0, 10'h155, 16'h0001, 10'h3FF, 0, 0, 4'h1);
    // mid-operation reset
    for (int i = 0; i < 5; i++)
      add(0, 16'h4000, 16'h0060 + 16'(i), 1, 0, 10'h155, 16'h0, 10'h3FF, 1, 8'h60, 4'hC);
    add(0, 16'h1000, 16'h02AA, 1, 0, 10'h155, 16'h0, 10'h2AA, 1, 0, 4'h6);
    add(0, 16'h4001, 16'h0, 0, 0, 10'h155, 16'h0005, 10'h2AA, 1, 0, 4'h7);
    add(0, 16'h0034, 16'h1234, 1, 0, 10'h155, 16'h0, 10'h2AA, 1, 0, 4'h0);
    add(1, 16'h0034, 16'hDEAD, 1, 1, 10'h155, 16'h0000, 10'h000, 0, 0, 4'h7);
    add(0, 16'h4001, 16'h0, 0, 0, 10'h155, 16'h2000, 10'h000, 0, 0, 4'h5);
    add(0, 16'h0034, 16'h0, 0, 0, 10'h155, 16'h1234, 10'h000, 0, 0, 4'h1);

    #2;
    foreach (tbl[i]) begin
      Reset = tbl[i].rst; ADDR = tbl[i].addr; DOUT = tbl[i].dout; W = tbl[i].w;
      TX_READY = tbl[i].rdy; SW = tbl[i].sw;
      tick();
      if (tbl[i].chk[0]) chk($sformatf("vec%0d DIN", i), DIN, tbl[i].edin);
      if (tbl[i].chk[1]) chk($sformatf("vec%0d LEDR", i), 16'(LEDR), 16'(tbl[i].eled));
      if (tbl[i].chk[2]) chk($sformatf("vec%0d TX_VALID", i), 16'(TX_VALID), 16'(tbl[i].evld));
      if (tbl[i].chk[3]) chk($sformatf("vec%0d TX_DATA", i), 16'(TX_DATA), 16'(tbl[i].etx));
    end

    // ---------------- random traffic vs model ----------------
    Reset = 1; W = 0; TX_READY = 0; tick(); Reset = 0;
    for (int i = 0; i < 256; i++) begin
      ADDR = 16'(i); DOUT = 16'($urandom); W = 1; tick();
    end
    W = 0;
    for (int n = 0; n < 2500; n++) begin
      int regs [10] = '{0, 0, 1, 3, 4, 4, 4, 5, 2, 9};
      int rg = regs[$urandom_range(0, 9)];
      ADDR = {4'(rg), 12'($urandom)};
      DOUT = 16'($urandom);
      W = ($urandom_range(0, 1) == 1);
      if (rg == 5 && $urandom_range(0, 3) != 0) W = 0;
      TX_READY = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) SW = 10'($urandom);
      Reset = ($urandom_range(0, 199) == 0);
      tick();
      if (m_din_ok) chk("rand DIN", DIN, m_din);
      chk("rand LEDR", 16'(LEDR), 16'(m_led));
      chk("rand TX_VALID", 16'(TX_VALID), 16'(m_q.size() != 0));
      if (m_q.size() != 0) chk("rand TX_DATA", 16'(TX_DATA), 16'(m_q[0]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_responder.md
# bus_responder

Memory-mapped bus target for the 16-bit processor's memory port. It decodes the processor's registered ADDR, DOUT and W outputs. It serves reads through a registered DIN with one-cycle latency and provides on-chip RAM, an LED register, a switch input, a free-running timer, and a byte-wide transmit FIFO with a valid/ready output stream. It sits between the processor and the board I/O, replacing a bare RAM on the processor's DIN/ADDR/DOUT/W nets.

## Interface
Parameters:
- AW, 8, RAM address width; RAM holds 2^AW 16-bit words.
- FD, 8, TX FIFO depth in bytes; power of two, 2..16.

Ports:
- Clock  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- ADDR  in  16  word address from the processor.
- DOUT  in  16  write data from the processor.
- W  in  1  write strobe; one write per cycle W=1.
- DIN  out  16  registered read data to the processor.
- SW  in  10  board switches (asynchronous).
- LEDR  out  10  LED register.
- TX_DATA  out  8  FIFO head byte.
- TX_VALID  out  1  FIFO non-empty.
- TX_READY  in  1  downstream accepts the head byte.

## Operation
Region select is ADDR[15:12]. Offsets above the implemented range alias within a region.
- 0x0, RAM: word index ADDR[AW-1:0]. Read returns the stored word. Write stores DOUT. RAM contents are not reset.
- 0x1, LEDR: write sets LEDR <= DOUT[9:0]. Read returns {6'b0, LEDR}.
- 0x3, SW: read returns {6'b0, sw_sync}. sw_sync is SW after a two-flop synchronizer. Writes are ignored.
- 0x4, TX FIFO, decoded by ADDR[0]:
  - Offset 0, write: push DOUT[7:0]. Read returns 0.
  - Offset 1, read: status {ovf, full, empty, 8'b0, count[4:0]}.
  - Offset 1, write with DOUT[15]=1: clears ovf. Other bits of the write are ignored.
- 0x5, TIMER: 16-bit up-counter, +1 every cycle, wraps from 0xFFFF to 0x0000.
  - Write loads DOUT; the next cycle shows DOUT, and counting resumes after that.
  - Read returns the counter value.
- All other regions: read returns 0x0000; writes are ignored.
- Reads have no side effects. The processor presents fetch addresses every cycle, so no state may change on a read.

FIFO rules:
- Circular buffer of FD entries with read and write pointers and a count of width 5.
- TX_DATA = mem[rd_ptr], first-word fall-through.
- TX_VALID = (count != 0).
- Pop when TX_VALID && TX_READY: rd_ptr advances, count decrements.
- Push is accepted when count < FD, or when a pop happens in the same cycle.
- Push with count == FD and no pop: byte dropped, ovf <= 1 (sticky). Pointers and count unchanged.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pop on empty cannot happen, because TX_VALID = 0.
- Pointers wrap modulo FD.
- full = (count == FD). empty = (count == 0).

## Timing
- DIN <= read_mux(ADDR) on every posedge. Data for the ADDR present in cycle N appears on DIN in cycle N+1. This matches the processor's one wait-cycle fetch and ld sequencing.
- A write takes effect on the posedge where W=1.
- Read-after-write to the same location in the next cycle returns the new data.
- A read in the same cycle as a write returns the old value (RAM is read-first).
- TIMER read: DIN in cycle N+1 holds the counter value from cycle N.
- TX FIFO timing:
  - A push at edge E makes TX_VALID high from E if the FIFO was empty.
  - A pop at edge E presents the next head after E.
  - Status reads reflect the count as of the cycle ADDR was presented.
- SW latency: 2 cycles through the synchronizer, then 1 cycle through DIN.
- Reset, sampled on posedge with Reset=1, regardless of any write or handshake in progress:
  - DIN = 0, LEDR = 0, timer = 0, sw_sync = 0.
  - FIFO: pointers = 0, count = 0, ovf = 0, so TX_VALID = 0.
  - A W=1 coincident with Reset is ignored.
  - TX_DATA after reset is don't-care while TX_VALID = 0.
  - RAM contents are retained across reset.

## Test plan
- RAM round trip: write 0xBEEF to 0x0012, then read 0x0012 → DIN = 0xBEEF one cycle after ADDR. Read 0x0112 (AW=8 alias) → 0xBEEF. Read 0x2000 → 0x0000.
- LED/SW: write 0x03FF to 0x1000 → LEDR = 0x3FF next cycle. Set SW = 0x155 → DIN = 0x0155 from reading 0x3000 no later than the 3rd cycle after the SW change.
- FIFO fill and overflow (FD=8, TX_READY=0):
  - Push 0x41..0x48, then status read → 0x4008 (full, count 8).
  - 9th push 0x49 → dropped, status = 0xC008.
  - Write 0x8000 to 0x4001 → status = 0x4008.
- FIFO drain with simultaneous traffic:
  - Set TX_READY=1 and capture the stream → 0x41..0x48 in order, then TX_VALID = 0 and status = 0x2000.
  - With count = 8, push and pop in the same cycle → push accepted, count stays 8, ovf stays 0.
- Timer: write 0xFFFE to 0x5000 → counter shows 0xFFFE, 0xFFFF, 0x0000, 0x0001 on consecutive cycles. Reads return matching values delayed one cycle.
- Mid-operation reset: with FIFO count = 5, LEDR = 0x2AA, and W=1 asserted in the reset cycle → after reset, TX_VALID = 0, status = 0x2000, LEDR = 0, DIN = 0. The write is not performed. A previously written RAM word reads back unchanged.
